sdram_arbiter: RTL and testbench

Two-master arbiter and request sequencer in front of the `sdram_top` controller on the Tang board. It shares the single SDRAM port between the CPU bus (master 0) and a second bus master (master 1: disk DMA or video fetch) using round-robin arbitration. It holds each SDRAM request until the controller acknowledges it, registers address, write data, byte masks and read data, and returns a stb/ack handshake to each master. It replaces the board-level reply former and the byte-mask latch, and adds a watchdog so a lost controller ack cannot hang the bus.

---
 rtl/dvk_sdram_pkg.sv | 16 +
 rtl/rr_arb2.sv | 19 +
 rtl/sdram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvk_sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM encoding, master indices
// and the default watchdog load.
package dvk_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int M_CPU = 0;
  localparam int M_AUX = 1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, under contention the
// requester that was not served last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single sdram_top port between the CPU bus and an auxiliary
// master, holding each request until acked or until the watchdog expires.
module sdram_arbiter
  import dvk_sdram_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk_p,
  input  logic        reset,
  input  logic        init_done,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [1:0]  m0_sel,
  input  logic [20:0] m0_adr,
  input  logic [15:0] m0_wdat,
  output logic [15:0] m0_rdat,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [1:0]  m1_sel,
  input  logic [20:0] m1_adr,
  input  logic [15:0] m1_wdat,
  output logic [15:0] m1_rdat,
  output logic        m1_ack,
  output logic        sd_wr_req,
  output logic        sd_rd_req,
  input  logic        sd_wr_ack,
  input  logic        sd_rd_ack,
  output logic [20:0] sd_adr,
  output logic [15:0] sd_wdat,
  input  logic [15:0] sd_rdat,
  output logic [1:0]  sd_dm,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT);

  arb_state_t  state, state_d;
  logic        last;
  logic        owner;
  logic        we_r;
  logic [7:0]  wdog;
  logic [15:0] rdat0, rdat1;
  logic [1:0]  pick;
  logic        gnt_load, ack_hit, tout_hit;
  logic        owner_stb, ctl_ack;
  logic        we_in;
  logic [1:0]  sel_in;
  logic [20:0] adr_in;
  logic [15:0] wdat_in;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_stb, m0_stb}),
    .last (last),
    .gnt  (pick)
  );

  assign we_in   = pick[M_AUX] ? m1_we   : m0_we;
  assign sel_in  = pick[M_AUX] ? m1_sel  : m0_sel;
  assign adr_in  = pick[M_AUX] ? m1_adr  : m0_adr;
  assign wdat_in = pick[M_AUX] ? m1_wdat : m0_wdat;

  assign owner_stb = owner ? m1_stb : m0_stb;
  assign ctl_ack   = we_r ? sd_wr_ack : sd_rd_ack;

  always_comb begin
    state_d  = state;
    gnt_load = 1'b0;
    ack_hit  = 1'b0;
    tout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (init_done && (m0_stb || m1_stb)) begin
          gnt_load = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A controller ack in the watchdog's final cycle still counts as success
        if (ctl_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (wdog == 8'd1) begin
          tout_hit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!owner_stb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      we_r        <= 1'b0;
      wdog        <= 8'd0;
      rdat0       <= 16'h0000;
      rdat1       <= 16'h0000;
      sd_adr      <= 21'd0;
      sd_wdat     <= 16'h0000;
      sd_dm       <= 2'b00;
      grant       <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      if (gnt_load) begin
        owner   <= pick[M_AUX];
        grant   <= pick;
        we_r    <= we_in;
        sd_adr  <= adr_in;
        sd_wdat <= wdat_in;
        sd_dm   <= we_in ? ~sel_in : 2'b00;
        wdog    <= WDOG_LOAD;
      end else if (state == REQ) begin
        wdog <= wdog - 8'd1;
      end
      if (ack_hit) begin
        last <= owner;
        if (!we_r) begin
          if (owner) rdat1 <= sd_rdat;
          else       rdat0 <= sd_rdat;
        end
      end
      if (tout_hit) begin
        timeout_err <= 1'b1;
        if (owner) rdat1 <= 16'hFFFF;
        else       rdat0 <= 16'hFFFF;
      end
      if ((state == DONE) && !owner_stb) grant <= 2'b00;
    end
  end

  assign sd_wr_req = (state == REQ) && we_r;
  assign sd_rd_req = (state == REQ) && !we_r;

  assign m0_ack  = (state == DONE) && (owner == 1'(M_CPU)) && m0_stb;
  assign m1_ack  = (state == DONE) && (owner == 1'(M_AUX)) && m1_stb;
  assign m0_rdat = m0_ack ? rdat0 : 16'h0000;
  assign m1_rdat = m1_ack ? rdat1 : 16'h0000;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios followed by randomized two-master traffic checked
// against a transaction-level model of the arbitration and handshake rules.
module tb_sdram_arbiter;
  import dvk_sdram_pkg::*;

  logic        clk_p = 1'b0;
  logic        reset = 1'b1;
  logic        init_done = 1'b1;
  logic        m0_stb = 1'b0, m0_we = 1'b0;
  logic [1:0]  m0_sel = 2'b00;
  logic [20:0] m0_adr = 21'd0;
  logic [15:0] m0_wdat = 16'h0;
  logic [15:0] m0_rdat;
  logic        m0_ack;
  logic        m1_stb = 1'b0, m1_we = 1'b0;
  logic [1:0]  m1_sel = 2'b00;
  logic [20:0] m1_adr = 21'd0;
  logic [15:0] m1_wdat = 16'h0;
  logic [15:0] m1_rdat;
  logic        m1_ack;
  logic        sd_wr_req, sd_rd_req;
  logic        sd_wr_ack = 1'b0, sd_rd_ack = 1'b0;
  logic [20:0] sd_adr;
  logic [15:0] sd_wdat;
  logic [15:0] sd_rdat = 16'h0;
  logic [1:0]  sd_dm;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  sdram_arbiter #(.TIMEOUT(8)) dut (
    .clk_p(clk_p), .reset(reset), .init_done(init_done),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_wdat(m0_wdat), .m0_rdat(m0_rdat), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_wdat(m1_wdat), .m1_rdat(m1_rdat), .m1_ack(m1_ack),
    .sd_wr_req(sd_wr_req), .sd_rd_req(sd_rd_req),
    .sd_wr_ack(sd_wr_ack), .sd_rd_ack(sd_rd_ack),
    .sd_adr(sd_adr), .sd_wdat(sd_wdat), .sd_rdat(sd_rdat), .sd_dm(sd_dm),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk_p = ~clk_p;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_p);
  endtask

  task automatic applyStimulus(input int m, input logic stb, input logic we, input logic [1:0] sel,
                               input logic [20:0] adr, input logic [15:0] wdat);
    if (m == 0) begin
      m0_stb = stb; m0_we = we; m0_sel = sel; m0_adr = adr; m0_wdat = wdat;
    end else begin
      m1_stb = stb; m1_we = we; m1_sel = sel; m1_adr = adr; m1_wdat = wdat;
    end
  endtask

  // Called in the first request cycle; the request must stay up for lat cycles.
  task automatic ctlAck(input logic isWrite, input int lat, input logic [15:0] data);
    for (int i = 1; i <= lat; i++) begin
      checkOutput("reqHeld", 64'({sd_wr_req, sd_rd_req}), isWrite ? 64'h2 : 64'h1);
      if (i == lat) begin
        sd_rdat = data;
        sd_wr_ack = isWrite;
        sd_rd_ack = !isWrite;
      end else begin
        tick();
      end
    end
    tick();
    sd_wr_ack = 1'b0;
    sd_rd_ack = 1'b0;
  endtask

  // Random-phase model state
  logic        rStb[2], rWe[2];
  logic [1:0]  rSel[2];
  logic [20:0] rAdr[2];
  logic [15:0] rWdat[2], expRdat[2];
  int          gap[2];
  int          served[2];
  logic        busy, inDone, owner, lastServed, ackDriven, prevAck;
  logic [1:0]  prevStb, expReq, expGrant, expAck, ackVec;
  logic [15:0] ctlRdat;
  int          ctlCnt;

  initial begin
    tick();
    checkOutput("rstCtl", 64'({sd_wr_req, sd_rd_req, grant, sd_dm, timeout_err}), 64'h0);
    checkOutput("rstBus", 64'({sd_adr, sd_wdat}), 64'h0);
    checkOutput("rstMst", 64'({m1_ack, m0_ack, m1_rdat, m0_rdat}), 64'h0);
    reset = 1'b0;

    // Single read by master 0
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000123, 16'h0000);
    tick();
    checkOutput("rdGrant", 64'(grant), 64'h1);
    checkOutput("rdBus", 64'({sd_adr, sd_dm}), 64'({21'h000123, 2'b00}));
    ctlAck(1'b0, 5, 16'hA5C3);
    checkOutput("rdAck", 64'({sd_wr_req, sd_rd_req, m1_ack, m0_ack}), 64'h1);
    checkOutput("rdData", 64'(m0_rdat), 64'hA5C3);
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000123, 16'h0000);
    tick();
    checkOutput("rdRelease", 64'({grant, m1_ack, m0_ack}), 64'h0);

    // Byte write by master 1
    applyStimulus(1, 1'b1, 1'b1, 2'b10, 21'h01ABCD, 16'h1234);
    tick();
    checkOutput("wrGrant", 64'(grant), 64'h2);
    checkOutput("wrBus", 64'({sd_adr, sd_wdat, sd_dm}), 64'({21'h01ABCD, 16'h1234, 2'b01}));
    ctlAck(1'b1, 2, 16'hDEAD);
    checkOutput("wrAck", 64'({m1_ack, m0_ack}), 64'h2);
    applyStimulus(1, 1'b0, 1'b1, 2'b10, 21'h01ABCD, 16'h1234);
    tick();

    // Contention: grants alternate with one idle cycle in between
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000011, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'b11, 21'h000022, 16'h0);
    tick();
    checkOutput("ctn1Grant", 64'({grant, sd_adr}), 64'({2'b01, 21'h000011}));
    ctlAck(1'b0, 1, 16'h1111);
    checkOutput("ctn1Ack", 64'({m1_ack, m0_ack, m0_rdat}), 64'({2'b01, 16'h1111}));
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000011, 16'h0);
    tick();
    checkOutput("ctnIdle1", 64'({grant, sd_wr_req, sd_rd_req}), 64'h0);
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000033, 16'h0);
    tick();
    checkOutput("ctn2Grant", 64'({grant, sd_adr}), 64'({2'b10, 21'h000022}));
    ctlAck(1'b0, 1, 16'h2222);
    checkOutput("ctn2Ack", 64'({m1_ack, m0_ack, m1_rdat}), 64'({2'b10, 16'h2222}));
    applyStimulus(1, 1'b0, 1'b0, 2'b11, 21'h000022, 16'h0);
    tick();
    checkOutput("ctnIdle2", 64'({grant, sd_wr_req, sd_rd_req}), 64'h0);
    tick();
    checkOutput("ctn3Grant", 64'({grant, sd_adr}), 64'({2'b01, 21'h000033}));
    ctlAck(1'b0, 1, 16'h3333);
    checkOutput("ctn3Ack", 64'({m1_ack, m0_ack}), 64'h1);
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000033, 16'h0);
    tick();

    // Abandon: master 0 walks away mid-request, master 1 waits behind it
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000044, 16'h0);
    tick();
    checkOutput("abGrant", 64'(grant), 64'h1);
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000044, 16'h0);
    applyStimulus(1, 1'b1, 1'b1, 2'b01, 21'h000055, 16'h5678);
    ctlAck(1'b0, 2, 16'h4444);
    checkOutput("abNoAck", 64'({m1_ack, m0_ack}), 64'h0);
    tick();
    checkOutput("abIdle", 64'({grant, m1_ack, m0_ack, sd_wr_req, sd_rd_req}), 64'h0);
    tick();
    checkOutput("abNext", 64'({grant, sd_adr, sd_wdat, sd_dm}), 64'({2'b10, 21'h000055, 16'h5678, 2'b10}));
    ctlAck(1'b1, 1, 16'h0000);
    checkOutput("abNextAck", 64'({m1_ack, m0_ack}), 64'h2);
    applyStimulus(1, 1'b0, 1'b1, 2'b01, 21'h000055, 16'h5678);
    tick();

    // Timeout: no controller ack for the full watchdog period
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000066, 16'h0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      checkOutput("toHeld", 64'({sd_wr_req, sd_rd_req, timeout_err}), 64'h2);
      tick();
    end
    checkOutput("toErr", 64'({timeout_err, sd_wr_req, sd_rd_req}), 64'h4);
    checkOutput("toAck", 64'({m1_ack, m0_ack, m0_rdat}), 64'({2'b01, 16'hFFFF}));
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000066, 16'h0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000077, 16'h0);
    tick();
    ctlAck(1'b0, 3, 16'hBEEF);
    checkOutput("toRecover", 64'({timeout_err, m0_ack, m0_rdat}), 64'({2'b11, 16'hBEEF}));
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 21'h000077, 16'h0);
    tick();

    // Init gate, then reset in the middle of a request
    init_done = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 2'b11, 21'h000088, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("initGate", 64'({grant, sd_wr_req, sd_rd_req}), 64'h0);
    end
    init_done = 1'b1;
    tick();
    checkOutput("initGrant", 64'({grant, sd_wr_req, sd_rd_req}), 64'({2'b10, 2'b01}));
    reset = 1'b1;
    tick();
    checkOutput("rstInReq", 64'({grant, sd_wr_req, sd_rd_req, timeout_err, m1_ack, m0_ack, sd_dm}), 64'h0);
    checkOutput("rstInReqBus", 64'({sd_adr, sd_wdat}), 64'h0);
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 21'h000099, 16'h0);
    tick();
    checkOutput("rstLast", 64'(grant), 64'h1);

    applyStimulus(0, 1'b0, 1'b0, 2'b00, 21'h0, 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 2'b00, 21'h0, 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized traffic against the transaction model
    busy = 1'b0; inDone = 1'b0; owner = 1'b0; lastServed = 1'b1;
    ackDriven = 1'b0; ctlCnt = -1; ctlRdat = 16'h0;
    for (int m = 0; m < 2; m++) begin
      rStb[m] = 1'b0; rWe[m] = 1'b0; rSel[m] = 2'b00; rAdr[m] = 21'd0;
      rWdat[m] = 16'h0; expRdat[m] = 16'h0; gap[m] = m; served[m] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      prevStb = {m1_stb, m0_stb};
      prevAck = ackDriven;
      if (!busy) begin
        if (prevStb != 2'b00) begin
          owner = (prevStb == 2'b11) ? ~lastServed : prevStb[1];
          busy = 1'b1;
          inDone = 1'b0;
          served[owner]++;
        end
      end else if (!inDone) begin
        if (prevAck) begin
          inDone = 1'b1;
          lastServed = owner;
          if (!rWe[owner]) expRdat[owner] = ctlRdat;
        end
      end else if (!prevStb[owner]) begin
        busy = 1'b0;
      end

      expReq   = (busy && !inDone) ? (rWe[owner] ? 2'b10 : 2'b01) : 2'b00;
      expGrant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
      expAck   = (busy && inDone) ? expGrant : 2'b00;
      ackVec   = {m1_ack, m0_ack};
      checkOutput("rndReq", 64'({sd_wr_req, sd_rd_req}), 64'(expReq));
      checkOutput("rndGrant", 64'(grant), 64'(expGrant));
      checkOutput("rndAck", 64'(ackVec), 64'(expAck));
      if (expReq != 2'b00)
        checkOutput("rndBus", 64'({sd_adr, sd_wdat, sd_dm}),
                    64'({rAdr[owner], rWdat[owner], rWe[owner] ? ~rSel[owner] : 2'b00}));
      if (expAck != 2'b00)
        checkOutput("rndRdat", 64'({m1_rdat, m0_rdat}),
                    owner ? 64'({expRdat[1], 16'h0}) : 64'({16'h0, expRdat[0]}));

      if (ackDriven) begin
        sd_wr_ack = 1'b0;
        sd_rd_ack = 1'b0;
        ackDriven = 1'b0;
      end else if (sd_wr_req || sd_rd_req) begin
        if (ctlCnt < 0) ctlCnt = int'($urandom_range(0, 4));
        if (ctlCnt == 0) begin
          ctlRdat = 16'($urandom);
          sd_rdat = ctlRdat;
          sd_wr_ack = sd_wr_req;
          sd_rd_ack = sd_rd_req;
          ackDriven = 1'b1;
          ctlCnt = -1;
        end else begin
          ctlCnt--;
        end
      end

      for (int m = 0; m < 2; m++) begin
        if (rStb[m]) begin
          if (ackVec[m]) begin
            rStb[m] = 1'b0;
            gap[m] = int'($urandom_range(0, 3));
          end
        end else if (gap[m] == 0) begin
          rStb[m] = 1'b1;
          rWe[m] = 1'($urandom);
          rSel[m] = 2'($urandom);
          rAdr[m] = 21'($urandom);
          rWdat[m] = 16'($urandom);
        end else begin
          gap[m]--;
        end
        applyStimulus(m, rStb[m], rWe[m], rSel[m], rAdr[m], rWdat[m]);
      end
    end
    checkOutput("rndNoTimeout", 64'(timeout_err), 64'h0);
    checkOutput("rndBothServed", 64'((served[0] > 10) && (served[1] > 10)), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
